// File: rtl/node_link_pkg.sv
// ---------------------------------------------------------------------------
// node_link_pkg
// Shared types for the node <-> router byte link.
//   pkt_t       : 32-bit packet layout {src, dest, data}. The router reuses
//                 this layout for its destination decode.
//   tx_state_t  : injector FSM states, one per byte slot of a packet.
//   LINK_BYTES  : bytes per packet on the 8-bit link.
//   pkt_fields_ok : header legality test applied at enqueue time.
// ---------------------------------------------------------------------------
package node_link_pkg;

    localparam int LINK_BYTES = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } tx_state_t;

    // A packet is legal when it names this node as its source and targets
    // an existing destination.
    function automatic logic pkt_fields_ok(
        input logic [3:0] src,
        input logic [3:0] dest,
        input logic [3:0] node_id,
        input logic [3:0] max_dest
    );
        return (src == node_id) && (dest <= max_dest);
    endfunction

endpackage

// File: rtl/node_packet_tx_if.sv
// ---------------------------------------------------------------------------
// node_packet_tx_if
// Bundles the two handshakes seen by the packet injector:
//   node side   : pkt_valid, pkt_data (pkt_t), pkt_ready
//   router side : free_outbound, put_outbound, payload_outbound
// Modports:
//   slave  : the injector (consumes packets, drives the byte link)
//   master : the surrounding node logic plus router inbound port
// ---------------------------------------------------------------------------
interface node_packet_tx_if;

    logic                 pkt_valid;
    node_link_pkg::pkt_t  pkt_data;
    logic                 pkt_ready;
    logic                 free_outbound;
    logic                 put_outbound;
    logic [7:0]           payload_outbound;

    modport slave (
        input  pkt_valid,
        input  pkt_data,
        output pkt_ready,
        input  free_outbound,
        output put_outbound,
        output payload_outbound
    );

    modport master (
        output pkt_valid,
        output pkt_data,
        input  pkt_ready,
        output free_outbound,
        input  put_outbound,
        input  payload_outbound
    );

endinterface

// File: rtl/node_tx_fifo.sv
// ---------------------------------------------------------------------------
// node_tx_fifo
// DEPTH-deep synchronous FIFO holding whole packets for the injector.
// Head word is visible combinationally so the first byte can go out in the
// same cycle the packet is popped.
// Ports:
//   clk, rst_b   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  write wdata at tail (caller guarantees not full)
//   pop          drop head (caller guarantees not empty)
//   head         word at head of queue
//   count        words currently stored, 0..DEPTH
// ---------------------------------------------------------------------------
module node_tx_fifo
    import node_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = LINK_BYTES * 8
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so natural pointer overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/node_packet_tx.sv
// ---------------------------------------------------------------------------
// node_packet_tx
// Node-side injector for the router byte link. Accepts 32-bit packets from
// node logic, queues them, and sends each one MSB-first as four bytes using
// the free/put/payload handshake into a router inbound port.
//
// Optional build macro: NODE_TX_STATS_EN adds sent_count / stall_count.
//
// Parameters:
//   NODEID    node id expected in pkt_data.src
//   DEPTH     packet queue depth (power of 2, >= 2)
//   MAX_DEST  highest legal destination id
// Ports:
//   clk, rst_b     clock, asynchronous active-low reset
//   link           node_packet_tx_if.slave: pkt_valid/pkt_data/pkt_ready,
//                  free_outbound/put_outbound/payload_outbound
//   queue_count    packets waiting (the packet in flight is not counted)
//   tx_busy        a packet is on the link (FSM not idle)
//   pkt_sent       high in the cycle the last byte is driven
//   err_drop       one-cycle pulse after a rejected push
//   sent_count     (NODE_TX_STATS_EN) packets completed, saturating
//   stall_count    (NODE_TX_STATS_EN) idle cycles waiting on free, saturating
// ---------------------------------------------------------------------------
module node_packet_tx
    import node_link_pkg::*;
#(
    parameter int NODEID   = 0,
    parameter int DEPTH    = 4,
    parameter int MAX_DEST = 5
) (
    input  logic                        clk,
    input  logic                        rst_b,
    node_packet_tx_if.slave             link,
    output logic [$clog2(DEPTH+1)-1:0]  queue_count,
    output logic                        tx_busy,
    output logic                        pkt_sent,
    output logic                        err_drop
`ifdef NODE_TX_STATS_EN
    ,
    output logic [15:0]                 sent_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [3:0]      NODE_ID4  = 4'(NODEID);
    localparam logic [3:0]      MAX_DEST4 = 4'(MAX_DEST);

    tx_state_t   state;
    tx_state_t   state_nxt;
    pkt_t        in_pkt;
    pkt_t        head_pkt;
    logic [31:0] head_word;
    logic [23:0] shift_p1;
    logic        push_req;
    logic        fields_ok;
    logic        push_ok;
    logic        push_bad;
    logic        queue_nonempty;
    logic        launch;
    logic        put;
    logic [7:0]  payload;

    // ---- stage 0: enqueue decision ----------------------------------------
    assign in_pkt         = link.pkt_data;
    assign queue_nonempty = (queue_count != '0);
    // Ready looks only at the registered count, so a same-cycle pop never
    // opens a slot early.
    assign link.pkt_ready = (queue_count != CW'(DEPTH));
    assign push_req       = link.pkt_valid & link.pkt_ready;
    assign fields_ok      = pkt_fields_ok(in_pkt.src, in_pkt.dest, NODE_ID4, MAX_DEST4);
    assign push_ok        = push_req & fields_ok;
    assign push_bad       = push_req & ~fields_ok;

    node_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (LINK_BYTES * 8)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push_ok),
        .wdata (in_pkt),
        .pop   (launch),
        .head  (head_word),
        .count (queue_count)
    );

    assign head_pkt = head_word;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) err_drop <= 1'b0;
        else        err_drop <= push_bad;
    end

    // ---- stage 1: byte serializer -----------------------------------------
    // The header byte goes straight from the queue head at launch; the
    // remaining 24 bits are parked in shift_p1 and shifted out MSB-first.
    assign launch = (state == IDLE) & queue_nonempty & link.free_outbound;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        put       = 1'b0;
        payload   = 8'h00;
        pkt_sent  = 1'b0;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    put       = 1'b1;
                    payload   = {head_pkt.src, head_pkt.dest};
                    state_nxt = B1;
                end
            end
            B1: begin
                payload   = shift_p1[23:16];
                state_nxt = B2;
            end
            B2: begin
                payload   = shift_p1[23:16];
                state_nxt = B3;
            end
            B3: begin
                payload   = shift_p1[23:16];
                pkt_sent  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (launch)
            shift_p1 <= head_pkt.data;
        else if ((state == B1) || (state == B2))
            shift_p1 <= {shift_p1[15:0], 8'h00};
    end

    assign link.put_outbound     = put;
    assign link.payload_outbound = payload;
    assign tx_busy               = (state != IDLE);

`ifdef NODE_TX_STATS_EN
    // ---- stage 2: statistics ----------------------------------------------
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) return v + 16'd1;
        return v;
    endfunction

    logic stall;
    assign stall = (state == IDLE) & queue_nonempty & ~link.free_outbound;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sent_count  <= '0;
            stall_count <= '0;
        end else begin
            sent_count  <= sat_inc(sent_count, pkt_sent);
            stall_count <= sat_inc(stall_count, stall);
        end
    end
`endif

endmodule

// File: tb/tb_node_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_node_packet_tx
// Directed and randomized stimulus for node_packet_tx, checked every cycle
// against a queue-based reference model of the injector.
// ---------------------------------------------------------------------------
module tb_node_packet_tx;

    localparam int NODEID   = 0;
    localparam int DEPTH    = 4;
    localparam int MAX_DEST = 5;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    node_packet_tx_if link();

    logic [2:0]  queue_count;
    logic        tx_busy;
    logic        pkt_sent;
    logic        err_drop;
`ifdef NODE_TX_STATS_EN
    logic [15:0] sent_count;
    logic [15:0] stall_count;
`endif

    node_packet_tx #(
        .NODEID   (NODEID),
        .DEPTH    (DEPTH),
        .MAX_DEST (MAX_DEST)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .link        (link.slave),
        .queue_count (queue_count),
        .tx_busy     (tx_busy),
        .pkt_sent    (pkt_sent),
        .err_drop    (err_drop)
`ifdef NODE_TX_STATS_EN
        ,
        .sent_count  (sent_count),
        .stall_count (stall_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queued packets, bytes still owed for the packet in
    // flight, pending error pulse, statistics.
    logic [31:0] mq[$];
    logic [7:0]  minfl[$];
    bit          merr;
    int          msent;
    int          mstall;

    // Last observed DUT values, for explicit directed checks.
    logic        obs_put;
    logic [7:0]  obs_pay;
    logic        obs_sent;
    logic        obs_err;
    logic        obs_ready;
    logic [2:0]  obs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] d);
        return (int'(d[31:28]) == NODEID) && (int'(d[27:24]) <= MAX_DEST);
    endfunction

    task automatic model_clear();
        mq.delete();
        minfl.delete();
        merr   = 1'b0;
        msent  = 0;
        mstall = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs just
    // after, then advance the model at the rising edge.
    task automatic tb_step(input logic v, input logic [31:0] d, input logic f);
        bit          idle;
        bit          launch;
        bit          rdy;
        logic [31:0] hd;
        logic [7:0]  pay;
        @(negedge clk);
        link.pkt_valid     = v;
        link.pkt_data      = d;
        link.free_outbound = f;
        #1;
        idle   = (minfl.size() == 0);
        launch = idle && (mq.size() != 0) && f;
        rdy    = (mq.size() != DEPTH);
        hd     = (mq.size() != 0) ? mq[0] : 32'h0;
        pay    = launch ? hd[31:24] : (idle ? 8'h00 : minfl[0]);
        obs_put   = link.put_outbound;
        obs_pay   = link.payload_outbound;
        obs_sent  = pkt_sent;
        obs_err   = err_drop;
        obs_ready = link.pkt_ready;
        obs_count = queue_count;
        chk("put",       32'(link.put_outbound),     32'(launch));
        chk("payload",   32'(link.payload_outbound), 32'(pay));
        chk("pkt_ready", 32'(link.pkt_ready),        32'(rdy));
        chk("count",     32'(queue_count),           32'(mq.size()));
        chk("tx_busy",   32'(tx_busy),               32'(!idle));
        chk("pkt_sent",  32'(pkt_sent),              32'(minfl.size() == 1));
        chk("err_drop",  32'(err_drop),              32'(merr));
`ifdef NODE_TX_STATS_EN
        chk("sent_count",  32'(sent_count),  32'(msent));
        chk("stall_count", 32'(stall_count), 32'(mstall));
`endif
        @(posedge clk);
        if (minfl.size() == 1 && msent < 65535) msent++;
        if (idle && mq.size() != 0 && !f && mstall < 65535) mstall++;
        if (!idle) begin
            void'(minfl.pop_front());
        end else if (launch) begin
            hd = mq.pop_front();
            minfl.push_back(hd[23:16]);
            minfl.push_back(hd[15:8]);
            minfl.push_back(hd[7:0]);
        end
        merr = 1'b0;
        if (v && rdy) begin
            if (legal(d)) mq.push_back(d);
            else          merr = 1'b1;
        end
    endtask

    // Assert reset part-way through a cycle and check the asynchronous effect
    // before any clock edge arrives.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_b              = 1'b0;
        link.pkt_valid     = 1'b0;
        link.pkt_data      = '0;
        link.free_outbound = 1'b0;
        #1;
        model_clear();
        chk("rst_put",     32'(link.put_outbound),     32'd0);
        chk("rst_payload", 32'(link.payload_outbound), 32'd0);
        chk("rst_count",   32'(queue_count),           32'd0);
        chk("rst_ready",   32'(link.pkt_ready),        32'd1);
        chk("rst_busy",    32'(tx_busy),               32'd0);
        chk("rst_sent",    32'(pkt_sent),              32'd0);
        chk("rst_err",     32'(err_drop),              32'd0);
`ifdef NODE_TX_STATS_EN
        chk("rst_sent_count",  32'(sent_count),  32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        rst_b              = 1'b0;
        link.pkt_valid     = 1'b0;
        link.pkt_data      = '0;
        link.free_outbound = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);

        // Single packet with free high: bytes 02,34,56,78 from t+1 to t+4.
        do_reset();
        tb_step(1'b1, 32'h0234_5678, 1'b1);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("first_put",  32'(obs_put), 32'd1);
        chk("first_byte", 32'(obs_pay), 32'h02);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("byte1", 32'(obs_pay), 32'h34);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("byte2", 32'(obs_pay), 32'h56);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("byte3", 32'(obs_pay), 32'h78);
        chk("last_sent", 32'(obs_sent), 32'd1);
        tb_step(1'b0, 32'h0, 1'b1);

        // free low holds a queued packet; launch the cycle free rises.
        do_reset();
        tb_step(1'b1, 32'h0311_2233, 1'b0);
        repeat (5) tb_step(1'b0, 32'h0, 1'b0);
        chk("hold_put", 32'(obs_put), 32'd0);
`ifdef NODE_TX_STATS_EN
        chk("stall5", 32'(stall_count), 32'd5);
`endif
        tb_step(1'b0, 32'h0, 1'b1);
        chk("free_put", 32'(obs_put), 32'd1);
        repeat (4) tb_step(1'b0, 32'h0, 1'b1);

        // Fill the queue with free low; fifth push is refused.
        do_reset();
        for (int i = 0; i < 5; i++) tb_step(1'b1, 32'h0100_0000 + 32'(i), 1'b0);
        chk("full_ready", 32'(obs_ready), 32'd0);
        chk("full_count", 32'(obs_count), 32'd4);
        tb_step(1'b0, 32'h0, 1'b0);
        chk("full_count2", 32'(obs_count), 32'd4);
        repeat (18) tb_step(1'b0, 32'h0, 1'b1);

        // Two queued packets go out back to back, four cycles apart.
        do_reset();
        tb_step(1'b1, 32'h02AA_BBCC, 1'b0);
        tb_step(1'b1, 32'h0511_2233, 1'b0);
        repeat (9) tb_step(1'b0, 32'h0, 1'b1);
`ifdef NODE_TX_STATS_EN
        chk("sent2", 32'(sent_count), 32'd2);
`endif

        // Illegal headers: bad destination, then wrong source.
        do_reset();
        tb_step(1'b1, 32'h0F00_0000, 1'b1);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("bad_dest_err",   32'(obs_err),   32'd1);
        chk("bad_dest_count", 32'(obs_count), 32'd0);
        chk("bad_dest_put",   32'(obs_put),   32'd0);
        tb_step(1'b1, 32'h1100_0000, 1'b1);
        tb_step(1'b0, 32'h0, 1'b1);
        chk("bad_src_err", 32'(obs_err), 32'd1);

        // Reset while the serializer is in B2 with packets still queued.
        do_reset();
        for (int i = 0; i < 3; i++) tb_step(1'b1, 32'h0400_1000 + 32'(i), 1'b0);
        tb_step(1'b0, 32'h0, 1'b1);
        tb_step(1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (4) tb_step(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            d = {($urandom_range(0, 9) == 0) ? 4'd3 : 4'(NODEID),
                 4'($urandom_range(0, 7)),
                 24'($urandom)};
            tb_step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 9) < 7));
        end
        repeat (20) tb_step(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
